// File: rtl/sqrt_coproc_if.sv
// Start/done handshake plus byte-wide data-memory port shared by the CPU side
// (master) and the square-root engine (slave).
interface sqrt_coproc_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              Start;
    logic              Ack;
    logic              Busy;
    logic [ADDR_W-1:0] MemAddr;
    logic [7:0]        MemRdData;
    logic              MemWrEn;
    logic [7:0]        MemWrData;

    modport slave (
        input  Start,
        input  MemRdData,
        output Ack,
        output Busy,
        output MemAddr,
        output MemWrEn,
        output MemWrData
    );

    modport master (
        output Start,
        output MemRdData,
        input  Ack,
        input  Busy,
        input  MemAddr,
        input  MemWrEn,
        input  MemWrData
    );
endinterface

// File: rtl/sqrt_coproc.sv
// Fixed-function 8-bit rounded integer square root of a 16-bit operand held in data memory.
// Define SQRT_FLOOR_EN to return floor(sqrt(x)) instead of the round-half-up result.
module sqrt_coproc #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned OPND_HI_ADDR = 16,
    parameter int unsigned OPND_LO_ADDR = 17,
    parameter int unsigned RESULT_ADDR  = 18
) (
    input  logic          Clk,
    input  logic          Reset,
    sqrt_coproc_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ARMED = 4'd1,
        S_RD_HI = 4'd2,
        S_RD_LO = 4'd3,
        S_LOAD  = 4'd4,
        S_CALC  = 4'd5,
        S_ROUND = 4'd6,
        S_WRITE = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       op_q, op_d;
    logic [8:0]        rem_q, rem_d;
    logic [7:0]        root_q, root_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [10:0]       trial_rem_s;
    logic [10:0]       trial_sub_s;

    // State and datapath registers; reset also kills a pending write strobe at once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            op_q      <= 16'h0000;
            rem_q     <= 9'h000;
            root_q    <= 8'h00;
            cnt_q     <= 3'd0;
            addr_q    <= '0;
            wr_data_q <= 8'h00;
            wr_en_q   <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, datapath update and registered output decode from the next state.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rem_d       = rem_q;
        root_d      = root_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        trial_rem_s = {rem_q, op_q[15:14]};
        trial_sub_s = {1'b0, root_q, 2'b01};

        case (state_q)
            S_IDLE: begin
                if (bus.Start) state_d = S_ARMED;
                else           state_d = S_IDLE;
            end
            S_ARMED: begin
                if (!bus.Start) state_d = S_RD_HI;
                else            state_d = S_ARMED;
            end
            S_RD_HI: begin
                if (bus.Start) state_d = S_ARMED;
                else           state_d = S_RD_LO;
            end
            S_RD_LO: begin
                if (bus.Start) begin
                    state_d = S_ARMED;
                end else begin
                    op_d[15:8] = bus.MemRdData;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.Start) begin
                    state_d = S_ARMED;
                end else begin
                    op_d[7:0] = bus.MemRdData;
                    rem_d     = 9'h000;
                    root_d    = 8'h00;
                    cnt_d     = 3'd0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.Start) begin
                    state_d = S_ARMED;
                end else begin
                    // Restoring step: the remainder never exceeds 2*root, so 9 bits hold it.
                    if (trial_rem_s >= trial_sub_s) begin
                        rem_d  = 9'(trial_rem_s - trial_sub_s);
                        root_d = {root_q[6:0], 1'b1};
                    end else begin
                        rem_d  = 9'(trial_rem_s);
                        root_d = {root_q[6:0], 1'b0};
                    end
                    op_d  = {op_q[13:0], 2'b00};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = S_ROUND;
                    else               state_d = S_CALC;
                end
            end
            S_ROUND: begin
                if (bus.Start) begin
                    state_d = S_ARMED;
                end else begin
`ifdef SQRT_FLOOR_EN
                    root_d = root_q;
`else
                    if ((rem_q > {1'b0, root_q}) && (root_q != 8'hFF)) root_d = root_q + 8'd1;
                    else                                               root_d = root_q;
`endif
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE: begin
                if (bus.Start) state_d = S_ARMED;
                else           state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_RD_HI: addr_d = ADDR_W'(OPND_HI_ADDR);
            S_RD_LO: addr_d = ADDR_W'(OPND_LO_ADDR);
            S_WRITE: begin
                addr_d    = ADDR_W'(RESULT_ADDR);
                wr_data_d = root_d;
            end
            default: addr_d = addr_q;
        endcase

        wr_en_d = (state_d == S_WRITE);
        ack_d   = (state_d == S_DONE);
        busy_d  = (state_d >= S_RD_HI) && (state_d <= S_WRITE);
    end

    assign bus.MemAddr   = addr_q;
    assign bus.MemWrEn   = wr_en_q;
    assign bus.MemWrData = wr_data_q;
    assign bus.Ack       = ack_q;
    assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_sqrt_coproc.sv
// Directed and randomized bench for sqrt_coproc with a byte-wide synchronous memory model.
module tb_sqrt_coproc;

    logic       Clk;
    logic       Reset;
    logic [7:0] mem [256];
    logic [7:0] rd_q;
    logic       preload;
    logic [7:0] pre_hi, pre_lo;
    int         wr_count;
    int         pass_cnt;
    int         total_cnt;

    sqrt_coproc_if #(.ADDR_W(8)) bus_if ();

    sqrt_coproc #(
        .ADDR_W(8), .OPND_HI_ADDR(16), .OPND_LO_ADDR(17), .RESULT_ADDR(18)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus_if.slave)
    );

    assign bus_if.MemRdData = rd_q;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous-read RAM; preload port lets the bench stage operands and the sentinel.
    always @(posedge Clk) begin
        rd_q <= mem[bus_if.MemAddr];
        if (bus_if.MemWrEn) begin
            mem[bus_if.MemAddr] <= bus_if.MemWrData;
            wr_count <= wr_count + 1;
        end
        if (preload) begin
            mem[16] <= pre_hi;
            mem[17] <= pre_lo;
            mem[18] <= 8'hAA;
        end
    end

    // Rounded root from first principles: largest n with (n - 1/2)^2 <= x, i.e. (2n-1)^2 <= 4x.
    function automatic int ref_root(input int x);
        int best;
        best = 0;
        for (int n = 1; n < 256; n++) begin
`ifdef SQRT_FLOOR_EN
            if (n * n <= x) best = n;
`else
            if ((2 * n - 1) * (2 * n - 1) <= 4 * x) best = n;
`endif
        end
        return best;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic stage(input int x);
        pre_hi  = 8'(x >> 8);
        pre_lo  = 8'(x);
        preload = 1'b1;
        @(posedge Clk); #1;
        preload = 1'b0;
    endtask

    // Arms, then drops Start so the next rising edge is e0; returns just after e0.
    task automatic launch();
        bus_if.Start = 1'b1;
        @(posedge Clk); #1;
        bus_if.Start = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic run_txn(input int x, input string tag);
        int exp_root;
        int wc0;
        exp_root = ref_root(x);
        stage(x);
        wc0 = wr_count;
        launch();
        repeat (12) @(posedge Clk);
        #1;
        chk({tag, "_wren_e12"}, 32'(bus_if.MemWrEn), 32'd1);
        chk({tag, "_addr_e12"}, 32'(bus_if.MemAddr), 32'd18);
        chk({tag, "_wdata_e12"}, 32'(bus_if.MemWrData), 32'(exp_root));
        chk({tag, "_ack_e12"}, 32'(bus_if.Ack), 32'd0);
        chk({tag, "_busy_e12"}, 32'(bus_if.Busy), 32'd1);
        @(posedge Clk); #1;
        chk({tag, "_ack_e13"}, 32'(bus_if.Ack), 32'd1);
        chk({tag, "_busy_e13"}, 32'(bus_if.Busy), 32'd0);
        chk({tag, "_wren_e13"}, 32'(bus_if.MemWrEn), 32'd0);
        chk({tag, "_mem18"}, 32'(mem[18]), 32'(exp_root));
        repeat (3) @(posedge Clk);
        #1;
        chk({tag, "_ack_hold"}, 32'(bus_if.Ack), 32'd1);
        chk({tag, "_addr_hold"}, 32'(bus_if.MemAddr), 32'd18);
        chk({tag, "_one_write"}, 32'(wr_count - wc0), 32'd1);
        bus_if.Start = 1'b1;
        @(posedge Clk); #1;
        chk({tag, "_ack_drop"}, 32'(bus_if.Ack), 32'd0);
    endtask

    initial begin
        int wc0;
        int x;
        pass_cnt     = 0;
        total_cnt    = 0;
        wr_count     = 0;
        preload      = 1'b0;
        pre_hi       = 8'h00;
        pre_lo       = 8'h00;
        bus_if.Start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        Reset = 1'b0;
        #2;
        chk("rst_ack", 32'(bus_if.Ack), 32'd0);
        chk("rst_busy", 32'(bus_if.Busy), 32'd0);
        chk("rst_wren", 32'(bus_if.MemWrEn), 32'd0);
        chk("rst_addr", 32'(bus_if.MemAddr), 32'd0);
        chk("rst_wdata", 32'(bus_if.MemWrData), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("idle_no_launch", 32'(bus_if.Busy), 32'd0);

        run_txn(81, "x81");
        run_txn(0, "x0");
        run_txn(65535, "xffff");
        run_txn(65280, "xff00");
        run_txn(240, "x240");
        run_txn(241, "x241");
        run_txn(3, "x3");
        run_txn(2, "x2");
        run_txn(144, "x144");

        // Abort: Start rises during CALC, so nothing is written and Ack never rises.
        stage(81);
        wc0 = wr_count;
        launch();
        repeat (5) @(posedge Clk);
        #1;
        bus_if.Start = 1'b1;
        @(posedge Clk); #1;
        chk("abort_busy", 32'(bus_if.Busy), 32'd0);
        repeat (14) @(posedge Clk);
        #1;
        chk("abort_ack", 32'(bus_if.Ack), 32'd0);
        chk("abort_no_write", 32'(wr_count - wc0), 32'd0);
        chk("abort_mem18", 32'(mem[18]), 32'hAA);
        run_txn(81, "relaunch");

        // Reset while the write strobe is up suppresses the write.
        stage(81);
        launch();
        repeat (12) @(posedge Clk);
        #1;
        chk("rstmid_wren_before", 32'(bus_if.MemWrEn), 32'd1);
        Reset = 1'b0;
        #1;
        chk("rstmid_wren", 32'(bus_if.MemWrEn), 32'd0);
        chk("rstmid_ack", 32'(bus_if.Ack), 32'd0);
        chk("rstmid_busy", 32'(bus_if.Busy), 32'd0);
        @(posedge Clk); #1;
        chk("rstmid_mem18", 32'(mem[18]), 32'hAA);
        bus_if.Start = 1'b0;
        Reset = 1'b1;
        @(posedge Clk); #1;

        for (int k = 0; k < 16; k++) begin
            x = int'($urandom_range(0, 65535));
            run_txn(x, $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
